// File: rtl/pwm_pkg.sv
// pwm_pkg: shared state type and width default for the PWM dead-time stage
package pwm_pkg;
    typedef enum logic [2:0] {IDLE, HI_ON, DT_H2L, LO_ON, DT_L2H} pwm_dt_state_e;
    localparam int PWM_DT_WIDTH_DEFAULT = 16;
endpackage

// File: rtl/pwm_deadtime_gen.sv
// pwm_deadtime_gen: complementary gate drives with shadowed dead-time and per-side polarity
// Ports: clk/rst (async, active-high); enable (0 forces both drives off); pwm_raw, period_end
// from the PWM core; deadtime_cycles_i / use_default_deadtime select the dead-time;
// inv_hi / inv_lo make a side active-low; pwm_hi / pwm_lo gate drives; in_deadtime while
// both sides are held off between transitions; pulse_swallowed flags an aborted dead-time.
module pwm_deadtime_gen
    import pwm_pkg::*;
#(
    parameter int DT_WIDTH                = PWM_DT_WIDTH_DEFAULT,
    parameter int DEFAULT_DEADTIME_CYCLES = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                pwm_raw,
    input  logic                period_end,
    input  logic [DT_WIDTH-1:0] deadtime_cycles_i,
    input  logic                use_default_deadtime,
    input  logic                inv_hi,
    input  logic                inv_lo,
    output logic                pwm_hi,
    output logic                pwm_lo,
    output logic                in_deadtime,
    output logic                pulse_swallowed
);
    localparam logic [DT_WIDTH-1:0] DT_DEF = DT_WIDTH'(DEFAULT_DEADTIME_CYCLES);
    localparam logic [DT_WIDTH-1:0] ONE    = DT_WIDTH'(1);
    pwm_dt_state_e       state, state_d;
    logic [DT_WIDTH-1:0] cnt, cnt_d, dt_shadow, dt_src;
    logic                pwm_q, hi_on, lo_on, swallow, dt_zero;
    assign dt_src  = use_default_deadtime ? DT_DEF : deadtime_cycles_i;
    assign dt_zero = dt_shadow == '0;
    // Loads see the pre-edge shadow; a zero shadow swaps sides directly so cnt never wraps.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        swallow = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state)
                IDLE:    state_d = pwm_q ? HI_ON : LO_ON;
                HI_ON:   if (!pwm_q) begin
                    state_d = dt_zero ? LO_ON : DT_H2L;
                    cnt_d   = dt_zero ? cnt : dt_shadow - ONE;
                end
                LO_ON:   if (pwm_q) begin
                    state_d = dt_zero ? HI_ON : DT_L2H;
                    cnt_d   = dt_zero ? cnt : dt_shadow - ONE;
                end
                DT_H2L:  if (pwm_q) begin
                    state_d = HI_ON;
                    swallow = 1'b1;
                end else if (cnt == '0) state_d = LO_ON;
                else cnt_d = cnt - ONE;
                DT_L2H:  if (!pwm_q) begin
                    state_d = LO_ON;
                    swallow = 1'b1;
                end else if (cnt == '0) state_d = HI_ON;
                else cnt_d = cnt - ONE;
                default: state_d = IDLE;
            endcase
        end
    end
    // Drive enables are decoded from the next state so they change on the same edge as state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            hi_on           <= 1'b0;
            lo_on           <= 1'b0;
            in_deadtime     <= 1'b0;
            pulse_swallowed <= 1'b0;
        end else begin
            state           <= state_d;
            hi_on           <= state_d == HI_ON;
            lo_on           <= state_d == LO_ON;
            in_deadtime     <= state_d == DT_H2L || state_d == DT_L2H;
            pulse_swallowed <= swallow;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else cnt <= cnt_d;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_q     <= 1'b0;
            dt_shadow <= DT_DEF;
        end else begin
            pwm_q     <= pwm_raw;
            dt_shadow <= (period_end || state == IDLE) ? dt_src : dt_shadow;
        end
    end
    assign pwm_hi = hi_on ^ inv_hi;
    assign pwm_lo = lo_on ^ inv_lo;
`ifndef SYNTHESIS
    a_no_overlap: assert property (@(posedge clk) disable iff (rst) !(hi_on && lo_on));
`endif
endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// tb_pwm_deadtime_gen: scoreboard bench with a behavioural gate-drive model
module tb_pwm_deadtime_gen;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0, pwm_raw = 1'b0, period_end = 1'b0, use_default_deadtime = 1'b0;
    logic [15:0] deadtime_cycles_i = '0;
    logic        inv_hi = 1'b1, inv_lo = 1'b0;
    logic        pwm_hi, pwm_lo, in_deadtime, pulse_swallowed;

    pwm_deadtime_gen dut (
        .clk(clk), .rst(rst), .enable(enable), .pwm_raw(pwm_raw), .period_end(period_end),
        .deadtime_cycles_i(deadtime_cycles_i), .use_default_deadtime(use_default_deadtime),
        .inv_hi(inv_hi), .inv_lo(inv_lo), .pwm_hi(pwm_hi), .pwm_lo(pwm_lo),
        .in_deadtime(in_deadtime), .pulse_swallowed(pulse_swallowed)
    );

    always #5 clk = ~clk;

    int checks = 0, passed = 0;
    int indt_seen = 0, sw_seen = 0, hi_seen = 0, lo_off_seen = 0;
    logic [3:0] exp_q[$];

    // stimulus settings picked up by step()
    bit        s_en = 1'b1, s_ud = 1'b0, s_ih = 1'b1, s_il = 1'b0;
    int        s_dt = 0;

    // behavioural model: which side conducts (0 none, 1 high, 2 low) and the off-gap in progress
    int m_side, m_origin, m_elapsed, m_dt_used, m_shadow;
    bit m_idle, m_waiting, m_sw, m_q;

    function automatic void chk(string name, int act, int req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    endfunction

    function automatic void clr_stats();
        indt_seen = 0;
        sw_seen = 0;
        hi_seen = 0;
        lo_off_seen = 0;
    endfunction

    function automatic void model_reset();
        m_side = 0;
        m_idle = 1'b1;
        m_waiting = 1'b0;
        m_sw = 1'b0;
        m_q = 1'b0;
        m_shadow = 10;
        m_elapsed = 0;
        m_dt_used = 0;
        m_origin = 0;
    endfunction

    function automatic void model_step(bit en, bit raw, bit pe, int dt, bit ud);
        int want = m_q ? 1 : 2;
        int new_shadow = (pe || m_idle) ? (ud ? 10 : dt) : m_shadow;
        m_sw = 1'b0;
        if (!en) begin
            m_idle = 1'b1;
            m_side = 0;
            m_waiting = 1'b0;
        end else if (m_idle) begin
            m_idle = 1'b0;
            m_side = want;
        end else if (m_waiting) begin
            if (want == m_origin) begin
                m_side = m_origin;
                m_waiting = 1'b0;
                m_sw = 1'b1;
            end else if (m_elapsed >= m_dt_used) begin
                m_side = want;
                m_waiting = 1'b0;
            end else m_elapsed++;
        end else if (want != m_side) begin
            if (m_shadow == 0) m_side = want;
            else begin
                m_origin = m_side;
                m_side = 0;
                m_waiting = 1'b1;
                m_elapsed = 1;
                m_dt_used = m_shadow;
            end
        end
        m_shadow = new_shadow;
        m_q = raw;
    endfunction

    // one clock of stimulus: drive on the falling edge, predict the following rising edge
    task automatic step(input bit r, input bit raw, input bit pe);
        @(negedge clk);
        rst = r;
        enable = s_en;
        pwm_raw = raw;
        period_end = pe;
        deadtime_cycles_i = 16'(s_dt);
        use_default_deadtime = s_ud;
        inv_hi = s_ih;
        inv_lo = s_il;
        if (r) begin
            #1;
            chk("async_reset", {pwm_hi, pwm_lo, in_deadtime, pulse_swallowed}, {inv_hi, inv_lo, 2'b00});
            model_reset();
        end else model_step(s_en, raw, pe, s_dt, s_ud);
        exp_q.push_back({(m_side == 1) ^ s_ih, (m_side == 2) ^ s_il, m_waiting, m_sw});
    endtask

    task automatic run(input int n, input bit raw);
        repeat (n) step(1'b0, raw, 1'b0);
    endtask

    initial begin : monitor
        logic [3:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("outputs", {pwm_hi, pwm_lo, in_deadtime, pulse_swallowed}, e);
                chk("no_overlap", int'((pwm_hi ^ inv_hi) && (pwm_lo ^ inv_lo)), 0);
                if (in_deadtime) indt_seen++;
                if (pulse_swallowed) sw_seen++;
                if (pwm_hi ^ inv_hi) hi_seen++;
                if (!(pwm_lo ^ inv_lo)) lo_off_seen++;
            end
        end
    end

    initial begin : stimulus
        bit raw = 1'b0;
        model_reset();
        #3;
        chk("reset_state", {pwm_hi, pwm_lo, in_deadtime, pulse_swallowed}, 4'b1000);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        // dead-time of 4 on a low-to-high transition
        s_dt = 4;
        run(4, 1'b0);
        clr_stats();
        run(11, 1'b1);
        chk("dt4_deadtime_cycles", indt_seen, 4);
        chk("dt4_no_swallow", sw_seen, 0);
        // zero dead-time: direct swaps
        s_dt = 0;
        step(1'b0, 1'b1, 1'b1);
        run(2, 1'b1);
        clr_stats();
        for (int i = 0; i < 20; i++) run(1, i[0]);
        run(3, 1'b1);
        chk("dt0_no_deadtime", indt_seen, 0);
        chk("dt0_no_swallow", sw_seen, 0);
        // short high request inside a long dead-time is swallowed
        s_dt = 8;
        step(1'b0, 1'b0, 1'b1);
        run(14, 1'b0);
        clr_stats();
        run(3, 1'b1);
        run(12, 1'b0);
        chk("abort_one_pulse", sw_seen, 1);
        chk("abort_hi_never_on", hi_seen, 0);
        chk("abort_lo_off_cycles", lo_off_seen, 3);
        // shadowed dead-time follows period_end only
        s_dt = 4;
        step(1'b0, 1'b0, 1'b1);
        run(14, 1'b0);
        s_dt = 10;
        clr_stats();
        run(10, 1'b1);
        chk("shadow_old_dt", indt_seen, 4);
        step(1'b0, 1'b1, 1'b1);
        clr_stats();
        run(16, 1'b0);
        chk("shadow_new_dt", indt_seen, 10);
        // disable during DT_L2H, then re-enable with a high request
        run(3, 1'b1);
        s_en = 1'b0;
        step(1'b0, 1'b1, 1'b0);
        s_en = 1'b1;
        clr_stats();
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("reenable_hi_after_one_edge", hi_seen, 1);
        chk("reenable_no_deadtime", indt_seen, 0);
        // reset in the middle of a dead-time
        s_dt = 6;
        run(2, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        // randomized soak
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 3) == 0) raw = ~raw;
            s_en = $urandom_range(0, 24) != 0;
            s_dt = $urandom_range(0, 6);
            s_ud = $urandom_range(0, 15) == 0;
            if ($urandom_range(0, 99) == 0) begin
                s_ih = 1'($urandom_range(0, 1));
                s_il = 1'($urandom_range(0, 1));
            end
            step(1'($urandom_range(0, 299) == 0), raw, 1'($urandom_range(0, 7) == 0));
        end
        @(posedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
